io_bus_host: RTL and testbench

- Peripheral at the far end of the processor's byte I/O port.
- Consumes the processor's bus_out/hs_out and drives its bus_in/hs_in.
- Each four-phase handshake is a byte exchange:
  - the byte on bus_out is captured into an RX FIFO;
  - a byte from a TX FIFO is presented on bus_in.
- Host-side logic (testbench, UART bridge) uses valid/ready streams on both FIFOs.

---
 rtl/io_bus_host_pkg.sv | 17 +
 rtl/io_bus_host_if.sv | 10 +
 rtl/io_bus_host_byte_fifo.sv | 68 ++++++
 rtl/io_bus_host.sv | 128 ++++++++++++
 tb/tb_io_bus_host.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_host_pkg.sv
// Shared types and defaults for the io_bus_host byte-exchange peripheral.
package io_bus_host_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  localparam int         DEPTH_DEF = 4;
  localparam logic [7:0] FILL_DEF  = 8'h00;

  // Occupancy counters need one more bit than the pointers so "full" is representable.
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_bus_host_if.sv
// Processor byte I/O port: four-phase request/acknowledge plus a byte in each direction.
interface io_bus_host_if;
  logic       hs_out;
  logic [7:0] bus_out;
  logic       hs_in;
  logic [7:0] bus_in;

  modport master (output hs_out, output bus_out, input hs_in, input bus_in);
  modport slave  (input hs_out, input bus_out, output hs_in, output bus_in);
endinterface

// File: rtl/io_bus_host_byte_fifo.sv
// Synchronous byte FIFO; push/pop are qualified internally against full/empty.
module byte_fifo
  import io_bus_host_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        g_clk,
  input  logic                        g_clr,
  input  logic                        push,
  input  logic [7:0]                  din,
  input  logic                        pop,
  output logic [7:0]                  dout,
  output logic                        full,
  output logic                        empty,
  output logic [clog2p1(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2p1(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/io_bus_host.sv
// Byte I/O peripheral: each processor handshake swaps one byte between the RX and TX FIFOs.
// Optional irq output (TX has data) is built when IO_BUS_HOST_IRQ_EN is defined.
//
// state | meaning
// IDLE  | hs_in=0, waiting for hs_out with space in RX
// ACK   | hs_in=1, bus_in held, waiting for hs_out to drop
module io_bus_host
  import io_bus_host_pkg::*;
#(
  parameter int         DEPTH = DEPTH_DEF,
  parameter logic [7:0] FILL  = FILL_DEF
) (
  input  logic                       g_clk,
  input  logic                       g_clr,
  io_bus_host_if.slave               pbus,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [clog2p1(DEPTH)-1:0]  tx_count,
  output logic [clog2p1(DEPTH)-1:0]  rx_count,
`ifdef IO_BUS_HOST_IRQ_EN
  output logic                       irq,
`endif
  output logic                       underrun
);

  state_e     state_q, state_d;
  logic       hs_in_q, hs_in_d;
  logic [7:0] bus_in_q, bus_in_d;
  logic       underrun_q, underrun_d;

  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_head;
  logic       exchange;

  // rx_full comes from the registered count, so a same-cycle host pop cannot admit an exchange.
  assign exchange = (state_q == IDLE) && pbus.hs_out && !rx_full;

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (exchange),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .push  (exchange),
    .din   (pbus.bus_out),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    state_d    = state_q;
    hs_in_d    = hs_in_q;
    bus_in_d   = bus_in_q;
    underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (exchange) begin
          state_d    = ACK;
          hs_in_d    = 1'b1;
          bus_in_d   = tx_empty ? FILL : tx_head;
          underrun_d = tx_empty;
        end
      end
      ACK: begin
        if (!pbus.hs_out) begin
          state_d = IDLE;
          hs_in_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        hs_in_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      state_q    <= IDLE;
      hs_in_q    <= 1'b0;
      bus_in_q   <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_in_q    <= hs_in_d;
      bus_in_q   <= bus_in_d;
      underrun_q <= underrun_d;
    end
  end

  assign pbus.hs_in  = hs_in_q;
  assign pbus.bus_in = bus_in_q;
  assign underrun    = underrun_q;
  assign tx_ready    = ~tx_full;
  assign rx_valid    = ~rx_empty;

`ifdef IO_BUS_HOST_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = (tx_count != '0);

  always_ff @(posedge g_clk) begin
    if (g_clr) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  // Without the interrupt option the TX occupancy is only visible through tx_count.
`endif

endmodule

// File: tb/tb_io_bus_host.sv
// Self-checking bench for io_bus_host: queue-level reference model, directed tests, random traffic.
module tb_io_bus_host;
  import io_bus_host_pkg::*;

  localparam int         DEPTH = 4;
  localparam logic [7:0] FILL  = 8'h00;
  localparam int         CW    = clog2p1(DEPTH);

  logic          g_clk = 1'b0;
  logic          g_clr;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          underrun;
`ifdef IO_BUS_HOST_IRQ_EN
  logic          irq;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 g_clk = ~g_clk;

  io_bus_host_if pif ();

  io_bus_host #(.DEPTH(DEPTH), .FILL(FILL)) dut (
    .g_clk    (g_clk),
    .g_clr    (g_clr),
    .pbus     (pif),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_count (tx_count),
    .rx_count (rx_count),
`ifdef IO_BUS_HOST_IRQ_EN
    .irq      (irq),
`endif
    .underrun (underrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two byte queues plus the handshake flag, advanced once per rising edge.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         m_hs;
  bit         m_under;
  bit         m_irq;
  logic [7:0] m_bus;
  bit         model_ok = 1'b0;

  always @(posedge g_clk) begin
    int tn;
    int rn;
    bit ex;
    if (g_clr) begin
      txq.delete();
      rxq.delete();
      m_hs     = 1'b0;
      m_under  = 1'b0;
      m_irq    = 1'b0;
      m_bus    = 8'h00;
      model_ok = 1'b1;
    end else begin
      tn = txq.size();
      rn = rxq.size();
      ex = !m_hs && (pif.hs_out === 1'b1) && (rn < DEPTH);
      m_irq   = (tn != 0);
      m_under = ex && (tn == 0);
      if (ex) m_bus = (tn == 0) ? FILL : txq[0];
      if (ex && tn != 0) void'(txq.pop_front());
      if (tx_valid && tn < DEPTH) txq.push_back(tx_data);
      if (rx_ready && rn > 0) void'(rxq.pop_front());
      if (ex) rxq.push_back(pif.bus_out);
      if (ex) m_hs = 1'b1;
      else if (m_hs && !pif.hs_out) m_hs = 1'b0;
    end
  end

  always @(negedge g_clk) begin
    if (model_ok) begin
      chk("hs_in", pif.hs_in, m_hs);
      chk("bus_in", pif.bus_in, m_bus);
      chk("underrun", underrun, m_under);
      chk("tx_count", tx_count, txq.size());
      chk("rx_count", rx_count, rxq.size());
      chk("tx_ready", tx_ready, txq.size() < DEPTH);
      chk("rx_valid", rx_valid, rxq.size() > 0);
      if (rxq.size() > 0) chk("rx_data", rx_data, rxq[0]);
`ifdef IO_BUS_HOST_IRQ_EN
      chk("irq", irq, m_irq);
`endif
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic exchange(input logic [7:0] b, output logic [7:0] got);
    int n;
    pif.hs_out  = 1'b1;
    pif.bus_out = b;
    n = 0;
    while (pif.hs_in !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("hs_in_rise", pif.hs_in, 1'b1);
    got = pif.bus_in;
    pif.hs_out = 1'b0;
    n = 0;
    while (pif.hs_in !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("hs_in_fall", pif.hs_in, 1'b0);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] exp_rx [4];
    g_clr       = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    rx_ready    = 1'b0;
    pif.hs_out  = 1'b0;
    pif.bus_out = 8'h00;
    tick();
    g_clr = 1'b0;
    chk("rst_hs_in", pif.hs_in, 1'b0);
    chk("rst_bus_in", pif.bus_in, 8'h00);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_counts", {tx_count, rx_count}, '0);

    // single exchange
    push_tx(8'hA5);
    pif.hs_out  = 1'b1;
    pif.bus_out = 8'h3C;
    tick();
    chk("x1_hs_in", pif.hs_in, 1'b1);
    chk("x1_bus_in", pif.bus_in, 8'hA5);
    chk("x1_rx_data", rx_data, 8'h3C);
    chk("x1_rx_valid", rx_valid, 1'b1);
    chk("x1_tx_count", tx_count, 0);
    pif.hs_out = 1'b0;
    tick();
    chk("x1_hs_drop", pif.hs_in, 1'b0);
    chk("x1_bus_hold", pif.bus_in, 8'hA5);

    // underrun
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    pif.hs_out  = 1'b1;
    pif.bus_out = 8'h11;
    tick();
    chk("ur_bus_in", pif.bus_in, 8'h00);
    chk("ur_pulse", underrun, 1'b1);
    chk("ur_rx_count", rx_count, 1);
    pif.hs_out = 1'b0;
    tick();
    chk("ur_pulse_end", underrun, 1'b0);

    // RX backpressure
    exchange(8'h21, got);
    exchange(8'h22, got);
    exchange(8'h23, got);
    chk("bp_rx_full", rx_count, 4);
    pif.hs_out  = 1'b1;
    pif.bus_out = 8'h55;
    repeat (3) begin
      tick();
      chk("bp_hold", pif.hs_in, 1'b0);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("bp_after_pop", pif.hs_in, 1'b0);
    chk("bp_rx_count3", rx_count, 3);
    tick();
    chk("bp_rise", pif.hs_in, 1'b1);
    chk("bp_rx_count4", rx_count, 4);
    pif.hs_out = 1'b0;
    tick();
    exp_rx = '{8'h21, 8'h22, 8'h23, 8'h55};
    for (int i = 0; i < 4; i++) begin
      chk("bp_rx_order", rx_data, exp_rx[i]);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    chk("bp_drained", rx_valid, 1'b0);

    // ordering across a pointer wrap
    rx_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push_tx(8'(i));
      exchange(8'(8'h80 + i), got);
      chk("ord_bus_in", got, 8'(i));
    end
    tick();
    rx_ready = 1'b0;

    // reset mid-handshake
    tx_valid = 1'b1;
    tx_data = 8'hA1; tick();
    tx_data = 8'hA2; tick();
    tx_data = 8'hA3; tick();
    tx_valid = 1'b0;
    pif.hs_out  = 1'b1;
    pif.bus_out = 8'hC0;
    tick();
    chk("mr_ack", pif.hs_in, 1'b1);
    chk("mr_bus_in", pif.bus_in, 8'hA1);
    chk("mr_counts", {tx_count, rx_count}, {3'(2), 3'(1)});
    g_clr = 1'b1;
    tick();
    g_clr = 1'b0;
    chk("mr_hs_in", pif.hs_in, 1'b0);
    chk("mr_bus_clr", pif.bus_in, 8'h00);
    chk("mr_counts0", {tx_count, rx_count}, '0);
    chk("mr_tx_ready", tx_ready, 1'b1);
    chk("mr_rx_valid", rx_valid, 1'b0);
    tick();
    chk("mr_restart", pif.hs_in, 1'b1);
    chk("mr_restart_ur", underrun, 1'b1);
    pif.hs_out = 1'b0;
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

`ifdef IO_BUS_HOST_IRQ_EN
    push_tx(8'h77);
    chk("irq_lag", irq, 1'b0);
    tick();
    chk("irq_rise", irq, 1'b1);
    pif.hs_out  = 1'b1;
    pif.bus_out = 8'h00;
    tick();
    chk("irq_pop_bus", pif.bus_in, 8'h77);
    chk("irq_hold", irq, 1'b1);
    pif.hs_out = 1'b0;
    tick();
    chk("irq_fall", irq, 1'b0);
`endif

    // random traffic, occasional resets
    for (int c = 0; c < 4000; c++) begin
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = 8'($urandom);
      rx_ready = ($urandom_range(0, 3) == 0);
      g_clr    = ($urandom_range(0, 299) == 0);
      if (!pif.hs_out && !pif.hs_in && $urandom_range(0, 1) == 1) begin
        pif.hs_out  = 1'b1;
        pif.bus_out = 8'($urandom);
      end else if (pif.hs_out && pif.hs_in) begin
        pif.hs_out = 1'b0;
      end
      tick();
    end
    g_clr    = 1'b0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    pif.hs_out = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
